// File: rtl/jtkcpu_stkseq.sv
// Push/pull stack sequencer: walks a register postbyte, one bus strobe per byte (push 2 cycles/byte, pull 1).
// Ends with a one-cycle done in FIN; cen=0 stalls every state and output.
module jtkcpu_stkseq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    input  logic       pull,
    input  logic       ussel,
    input  logic [7:0] mask,
    input  logic [7:0] stack_bit,
    output logic [7:0] psh_sel,
    output logic       psh_hihalf,
    output logic       psh_ussel,
    output logic       pul_en,
    output logic       psh_dec,
    output logic       stack_busy,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic       done
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DEC  = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0] st;
    logic       pull_l;
    logic       second;
    logic       is16;
    logic       last;
    logic [7:0] sel_nx;

    // Bits 7..4 of the postbyte are the 16-bit registers.
    assign is16   = |stack_bit[7:4];
    assign last   = ~is16 | second;
    assign sel_nx = psh_sel & ~stack_bit;

    assign psh_dec    = (st == DEC);
    assign bus_wr     = (st == WR);
    assign bus_rd     = (st == RD);
    assign done       = (st == FIN);
    assign stack_busy = (st != IDLE);
    // Push sends the low half first, pull the high half first.
    assign psh_hihalf = (st == DEC || st == WR || st == RD) & is16 & (pull_l ? ~second : second);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            psh_sel   <= 8'h00;
            psh_ussel <= 1'b0;
            pull_l    <= 1'b0;
            second    <= 1'b0;
            pul_en    <= 1'b0;
        end else if (cen) begin
            case (st)
                IDLE: begin
                    if (start) begin
                        psh_sel   <= mask;
                        pull_l    <= pull;
                        psh_ussel <= ussel;
                        second    <= 1'b0;
                        pul_en    <= pull & (|mask);
                        if (mask == 8'h00)
                            st <= FIN;
                        else
                            st <= pull ? RD : DEC;
                    end
                end
                DEC: st <= WR;
                WR, RD: begin
                    if (last) begin
                        psh_sel <= sel_nx;
                        second  <= 1'b0;
                        if (sel_nx == 8'h00)
                            st <= FIN;
                        else
                            st <= (st == RD) ? RD : DEC;
                    end else begin
                        second <= 1'b1;
                        st     <= (st == RD) ? RD : DEC;
                    end
                end
                FIN: begin
                    st     <= IDLE;
                    pul_en <= 1'b0;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Randomised bench for jtkcpu_stkseq against a per-cycle expected-output list built from the postbyte.
module tb_jtkcpu_stkseq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       start = 1'b0;
    logic       pull = 1'b0;
    logic       ussel = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] stack_bit;
    logic [7:0] psh_sel;
    logic       psh_hihalf, psh_ussel, pul_en, psh_dec, stack_busy, bus_wr, bus_rd, done;
    logic [15:0] outv;
    logic [15:0] exp_q[$];
    int total = 0;
    int bad = 0;

    jtkcpu_stkseq dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .pull(pull), .ussel(ussel),
        .mask(mask), .stack_bit(stack_bit), .psh_sel(psh_sel), .psh_hihalf(psh_hihalf),
        .psh_ussel(psh_ussel), .pul_en(pul_en), .psh_dec(psh_dec), .stack_busy(stack_busy),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .done(done)
    );

    always #5 clk = ~clk;

    assign outv = {psh_sel, psh_ussel, psh_hihalf, pul_en, psh_dec, stack_busy, bus_wr, bus_rd, done};

    // Register file stand-in: pushes service the highest remaining bit, pulls the lowest.
    function automatic logic [7:0] pick(input logic [7:0] s, input logic up);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int b;
            b = up ? 7 - i : i;
            if (s[b]) r = 8'h01 << b;
        end
        return r;
    endfunction

    always_comb stack_bit = pick(psh_sel, pul_en);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] vec(input logic [7:0] sel, input logic us, input logic hi,
                                        input logic pe, input logic dec, input logic busy,
                                        input logic wr, input logic rd, input logic dn);
        return {sel, us, hi, pe, dec, busy, wr, rd, dn};
    endfunction

    // Expected outputs for every enabled cycle from start acceptance to FIN.
    task automatic build(input logic [7:0] m, input logic p, input logic u);
        logic [7:0] rem;
        exp_q.delete();
        rem = m;
        for (int k = 0; k < 8; k++) begin
            int b;
            b = p ? k : 7 - k;
            if (m[b]) begin
                for (int h = 0; h < ((b >= 4) ? 2 : 1); h++) begin
                    logic hi;
                    hi = (b >= 4) ? (p ? (h == 0) : (h == 1)) : 1'b0;
                    if (!p) exp_q.push_back(vec(rem, u, hi, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
                    exp_q.push_back(vec(rem, u, hi, p, 1'b0, 1'b1, !p, p, 1'b0));
                end
                rem[b] = 1'b0;
            end
        end
        exp_q.push_back(vec(8'h00, u, 1'b0, p & (m != 8'h00), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    endtask

    // mode 0: cen always 1, mode 1: cen alternates, mode 2: random cen.
    task automatic run_seq(input string tag, input logic [7:0] m, input logic p, input logic u, input int mode);
        int idx;
        int cyc;
        logic c;
        build(m, p, u);
        @(negedge clk);
        start = 1'b1; mask = m; pull = p; ussel = u; cen = 1'b1;
        @(negedge clk);
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 400) begin
            check(tag, outv, exp_q[idx]);
            start = ($urandom_range(0, 3) == 0);
            mask  = 8'($urandom);
            pull  = 1'($urandom);
            ussel = 1'($urandom);
            c = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom);
            cen = c;
            @(negedge clk);
            if (c) idx++;
            cyc++;
        end
        start = 1'b0;
        cen = 1'b1;
        if (idx < exp_q.size())
            check({tag, "_timeout"}, 16'(idx), 16'(exp_q.size()));
        check({tag, "_idle"}, outv, vec(8'h00, u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        int n;
        #1;
        check("reset", outv, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outv, 16'h0000);

        run_seq("push81_s", 8'h81, 1'b0, 1'b0, 0);
        run_seq("pullFF_u", 8'hFF, 1'b1, 1'b1, 0);
        run_seq("mask00", 8'h00, 1'b0, 1'b1, 0);
        run_seq("push10_cen", 8'h10, 1'b0, 1'b0, 1);
        run_seq("pushFF", 8'hFF, 1'b0, 1'b1, 0);
        run_seq("pull0F_cen", 8'h0F, 1'b1, 1'b0, 1);

        // Reset during a write strobe.
        build(8'h81, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; mask = 8'h81; pull = 1'b0; ussel = 1'b1; cen = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_reached", {15'd0, bus_wr}, 16'h0001);
        #2 rst = 1'b1;
        #1 check("rst_in_wr", outv, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold", outv, 16'h0000);
        rst = 1'b0;
        run_seq("after_rst", 8'h42, 1'b1, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] m;
            logic p;
            m = 8'($urandom);
            p = 1'($urandom);
            if (m == 8'h00) p = 1'b0;
            run_seq("rand", m, p, 1'($urandom), (i % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
